dm_cache_controller: RTL and testbench
======================================

Name: dm_cache_controller

Overview:
- Direct-mapped, write-back, write-allocate cache controller for the rv32i data path.
- Sits between the CPU load/store unit and main memory.
- Drives the single-word-per-line data array, which is a separate module: it supplies the write enable, index and write data, and consumes the array's asynchronous read data.
- Owns the tag/valid/dirty store internally.

Parameters:
- ADDR_W, 32, byte address width.
- OFFSET_W, 2, byte-offset bits. Ignored for indexing; forced to 0 on memory addresses.
- IDX_W, 5, index bits; 2**IDX_W lines.
- DATA_W, 32, line/word width.
- TAG_W (localparam), ADDR_W-IDX_W-OFFSET_W = 25.

Ports:
- iCLK  in  1  clock; all state updates on rising edge.
- iRST  in  1  synchronous active-high reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  ADDR_W  request byte address.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- data_we  out  1  data array write enable.
- idx  out  IDX_W  data array index.
- data_block_in  out  DATA_W  data array write data.
- data_block_out  in  DATA_W  data array read data (combinational on idx).
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1=write-back, 0=line fill.
- mem_addr  out  ADDR_W  word-aligned memory address.
- mem_wdata  out  DATA_W  write-back data.
- mem_rdata  in  DATA_W  fill data; valid when mem_ack=1.
- mem_ack  in  1  one-cycle completion from memory.
- hit_count  out  32  load/store hits since reset.
- miss_count  out  32  misses since reset.

Behaviour:
- Reset (iRST high at an edge):
  - state=IDLE; all valid and dirty bits cleared; tags don't-care.
  - cpu_ready=0, cpu_rdata=0, hit_count=0, miss_count=0.
  - Aborts any in-flight miss: mem_req low from the next cycle; a late mem_ack is ignored.
- Request latch: in IDLE, cpu_req=1 at an edge latches addr/we/wdata into req_* registers and moves to COMPARE.
- Field split:
  - tag = req_addr[ADDR_W-1 -: TAG_W]
  - index = req_addr[OFFSET_W +: IDX_W]
- idx output: cpu_addr index in IDLE; req_addr index in every other state.
- COMPARE (exactly one cycle); hit = valid[index] && tag_mem[index]==tag.
  - Load hit: cpu_rdata<=data_block_out; cpu_ready<=1 for one cycle; hit_count+1; ->IDLE.
  - Store hit: data_we=1, data_block_in=req_wdata in this cycle; dirty[index]<=1; cpu_ready<=1; cpu_rdata unchanged; hit_count+1; ->IDLE.
  - Miss, line clean or invalid: miss_count+1; ->ALLOCATE.
  - Miss, line valid and dirty: miss_count+1; ->WRITEBACK.
  - miss_count increments once per request, never on the post-fill COMPARE.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={tag_mem[index], index, OFFSET_W'b0}, mem_wdata=data_block_out.
  - Outputs held stable until mem_ack; then dirty[index]<=0 and ->ALLOCATE.
- ALLOCATE:
  - mem_req=1, mem_we=0, mem_addr={tag, index, 0}.
  - On mem_ack: data_we=1, data_block_in=mem_rdata (same cycle); tag_mem[index]<=tag, valid<=1, dirty<=0; ->COMPARE.
  - The re-compare always hits and completes the request; for a store it also marks the line dirty.
- Memory/array outputs are Moore-decoded from state and req_* registers. mem_req never asserts in IDLE or COMPARE.
- data_we asserts only in COMPARE (store hit) or in ALLOCATE with mem_ack.
- Latency, measured from the edge where cpu_req is sampled:
  - Hit: cpu_ready high after the 2nd edge.
  - Clean miss: fill-ack edge + 2.
  - Dirty miss: write-back ack + fill ack + 2.
- Back-to-back: CPU deasserts cpu_req during the cpu_ready cycle. The next request is sampled at the earliest one edge after returning to IDLE.
- Counters wrap from 0xFFFFFFFF to 0; no saturation.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Reset, then load 0x0000_0040 with mem returning 0xDEADBEEF after 3 cycles:
  - mem_req/mem_we=0 with mem_addr=0x40.
  - cpu_ready one cycle with cpu_rdata=0xDEADBEEF.
  - miss_count=1.
- Repeat load 0x40 -> cpu_ready after 2 edges, rdata 0xDEADBEEF, no mem_req, hit_count=1.
- Store 0x12345678 to 0x40 (hit), then load 0x1040 (same index 16, different tag):
  - write-back mem_we=1, mem_addr=0x40, mem_wdata=0x12345678.
  - then fill mem_addr=0x1040.
  - miss_count=2.
- Store miss to clean line 0x80 with wdata 0xA5A5A5A5:
  - fill happens, then store completes.
  - later eviction via 0x1080 writes back 0xA5A5A5A5 to 0x80.
- Assert iRST while in ALLOCATE waiting for mem_ack:
  - mem_req low next cycle.
  - a subsequent load 0x40 misses (valid cleared); counters 0 before the new miss.
- Spurious mem_ack in IDLE, and cpu_req held high through cpu_ready:
  - no state change on the spurious ack.
  - the held request is re-sampled and serviced as a second hit, hit_count+2.

Source files
------------

// File: rtl/dm_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Owns tag/valid/dirty state; the single-word data array lives outside.
module dm_cache_controller #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 2,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              data_we,
  output logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] data_block_in,
  input  logic [DATA_W-1:0] data_block_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int TAG_W  = ADDR_W - IDX_W - OFFSET_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam int LINES  = 2 ** IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_e;

  state_e              state_q, state_d;
  logic [LINE_W-1:0]   req_addr_q, req_addr_d;
  logic                req_we_q, req_we_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q [LINES];
  logic [TAG_W-1:0]    tag_d [LINES];
  logic                refill_q, refill_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic [31:0]         hit_count_q, hit_count_d;
  logic [31:0]         miss_count_q, miss_count_d;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [IDX_W-1:0]    cpu_idx;
  logic                hit;
  logic                unused_offset;

  // Byte-offset bits never participate in lookup or memory addressing.
  assign unused_offset = ^cpu_addr[OFFSET_W-1:0];

  assign req_tag = req_addr_q[LINE_W-1 -: TAG_W];
  assign req_idx = req_addr_q[IDX_W-1:0];
  assign cpu_idx = cpu_addr[OFFSET_W +: IDX_W];
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_ready  = cpu_ready_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    req_we_d      = req_we_q;
    req_wdata_d   = req_wdata_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    tag_d         = tag_q;
    refill_d      = refill_q;
    cpu_rdata_d   = cpu_rdata_q;
    cpu_ready_d   = 1'b0;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    data_we       = 1'b0;
    data_block_in = req_wdata_q;
    idx           = (state_q == IDLE) ? cpu_idx : req_idx;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = {req_tag, req_idx, {OFFSET_W{1'b0}}};
    mem_wdata     = data_block_out;

    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          req_addr_d  = cpu_addr[ADDR_W-1:OFFSET_W];
          req_we_d    = cpu_we;
          req_wdata_d = cpu_wdata;
          state_d     = COMPARE;
        end
      end
      COMPARE: begin
        refill_d = 1'b0;
        if (hit) begin
          cpu_ready_d = 1'b1;
          state_d     = IDLE;
          // The compare following a fill completes an already-counted miss.
          if (!refill_q) hit_count_d = hit_count_q + 32'd1;
          if (req_we_q) begin
            data_we          = 1'b1;
            dirty_d[req_idx] = 1'b1;
          end else begin
            cpu_rdata_d = data_block_out;
          end
        end else begin
          miss_count_d = miss_count_q + 32'd1;
          state_d      = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {tag_q[req_idx], req_idx, {OFFSET_W{1'b0}}};
        if (mem_ack) begin
          dirty_d[req_idx] = 1'b0;
          state_d          = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          data_we          = 1'b1;
          data_block_in    = mem_rdata;
          tag_d[req_idx]   = req_tag;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          refill_d         = 1'b1;
          state_d          = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      refill_q     <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_ready_q  <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      refill_q     <= refill_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_ready_q  <= cpu_ready_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Request latches and tags carry no reset; valid bits gate their use.
  always_ff @(posedge iCLK) begin
    req_addr_q  <= req_addr_d;
    req_we_q    <= req_we_d;
    req_wdata_q <= req_wdata_d;
    tag_q       <= tag_d;
  end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Self-checking bench for dm_cache_controller: directed vector table,
// multi-cycle corner sequences, and randomized traffic against a cache model.
module tb_dm_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        data_we;
  logic [4:0]  idx;
  logic [31:0] data_block_in, data_block_out;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  dm_cache_controller #(.ADDR_W(32), .OFFSET_W(2), .IDX_W(5), .DATA_W(32)) dut (
    .iCLK(clk), .iRST(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .data_we(data_we), .idx(idx), .data_block_in(data_block_in), .data_block_out(data_block_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // External single-word data array
  logic [31:0] darray [32];
  always @(posedge clk) if (data_we) darray[idx] <= data_block_in;
  assign data_block_out = darray[idx];

  // Main memory: untouched words read as addr ^ C0DE0000
  logic [31:0] mem_store [logic [31:0]];
  function automatic logic [31:0] backing_rd(input logic [31:0] a);
    return mem_store.exists(a) ? mem_store[a] : (a ^ 32'hC0DE_0000);
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } tx_t;
  tx_t txq[$];

  int unsigned resp_lat = 3;
  bit          resp_en  = 1'b1;
  int unsigned spur_cnt = 0;

  initial begin
    int unsigned wait_cnt;
    int unsigned spur_done;
    wait_cnt  = 0;
    spur_done = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (spur_cnt != spur_done) begin
        mem_ack   = 1'b1;
        spur_done = spur_done + 1;
      end else if (resp_en && mem_req) begin
        if (wait_cnt >= resp_lat) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          if (mem_we) mem_store[mem_addr] = mem_wdata;
          else        mem_rdata = backing_rd(mem_addr);
          txq.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata});
        end else begin
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Called at posedge+1 with the controller idle; returns at posedge+1.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int cyc, output int mreq_cyc);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk); #1;
    cpu_req  = 1'b0;
    cyc      = 1;
    mreq_cyc = 0;
    while (!cpu_ready && cyc < 300) begin
      if (mem_req) mreq_cyc++;
      @(posedge clk); #1;
      cyc++;
    end
    check1("ready_seen", cpu_ready, 1'b1);
    rdata = cpu_rdata;
    @(posedge clk); #1;
    check1("ready_pulse", cpu_ready, 1'b0);
  endtask

  task automatic check_txs(input int base, input logic ewb, input logic [31:0] wba,
                           input logic [31:0] wbd, input logic efill, input logic [31:0] fa);
    int nexp;
    nexp = (ewb ? 1 : 0) + (efill ? 1 : 0);
    check("tx_count", 32'(txq.size() - base), 32'(nexp));
    if (ewb && txq.size() > base) begin
      check1("wb_we", txq[base].we, 1'b1);
      check("wb_addr", txq[base].addr, wba);
      check("wb_data", txq[base].data, wbd);
    end
    if (efill && txq.size() > base + (ewb ? 1 : 0)) begin
      check1("fill_we", txq[base + (ewb ? 1 : 0)].we, 1'b0);
      check("fill_addr", txq[base + (ewb ? 1 : 0)].addr, fa);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, exp_rdata, exp_hits, exp_misses;
    logic        exp_wb;
    logic [31:0] wb_addr, wb_data;
    logic        exp_fill;
    logic [31:0] fill_addr;
  } vec_t;

  vec_t tbl [7];

  // Random-phase reference: architectural memory plus per-line tag state
  logic [31:0] truth [logic [31:0]];
  function automatic logic [31:0] truth_rd(input logic [31:0] a);
    return truth.exists(a) ? truth[a] : (a ^ 32'hC0DE_0000);
  endfunction
  logic        m_valid [32];
  logic        m_dirty [32];
  logic [24:0] m_tag   [32];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          cyc, mreq_cyc, base, pulses;
    logic        we, ehit, ewb;
    logic [31:0] a, wa, wd, wba, wbd, m_hits, m_misses, m_rdata;
    logic [4:0]  mi;
    logic [24:0] mt;

    tbl[0] = '{1'b0, 32'h40,   32'h0,        32'hDEADBEEF, 32'd0, 32'd1, 1'b0, 32'h0,  32'h0,        1'b1, 32'h40};
    tbl[1] = '{1'b0, 32'h40,   32'h0,        32'hDEADBEEF, 32'd1, 32'd1, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0};
    tbl[2] = '{1'b1, 32'h40,   32'h12345678, 32'hDEADBEEF, 32'd2, 32'd1, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0};
    tbl[3] = '{1'b0, 32'h1040, 32'h0,        32'hC0DE1040, 32'd2, 32'd2, 1'b1, 32'h40, 32'h12345678, 1'b1, 32'h1040};
    tbl[4] = '{1'b1, 32'h80,   32'hA5A5A5A5, 32'hC0DE1040, 32'd2, 32'd3, 1'b0, 32'h0,  32'h0,        1'b1, 32'h80};
    tbl[5] = '{1'b0, 32'h1080, 32'h0,        32'hC0DE1080, 32'd2, 32'd4, 1'b1, 32'h80, 32'hA5A5A5A5, 1'b1, 32'h1080};
    tbl[6] = '{1'b0, 32'h80,   32'h0,        32'hA5A5A5A5, 32'd2, 32'd5, 1'b0, 32'h0,  32'h0,        1'b1, 32'h80};

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_store[32'h40] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check1("rst_ready", cpu_ready, 1'b0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_hits", hit_count, 32'h0);
    check("rst_misses", miss_count, 32'h0);
    check1("rst_mem_req", mem_req, 1'b0);

    for (int i = 0; i < 7; i++) begin
      base = txq.size();
      do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, cyc, mreq_cyc);
      check("vec_rdata", rd, tbl[i].exp_rdata);
      check("vec_hits", hit_count, tbl[i].exp_hits);
      check("vec_misses", miss_count, tbl[i].exp_misses);
      check_txs(base, tbl[i].exp_wb, tbl[i].wb_addr, tbl[i].wb_data, tbl[i].exp_fill, tbl[i].fill_addr);
      if (!tbl[i].exp_fill) begin
        check("vec_hit_latency", 32'(cyc), 32'd2);
        check("vec_hit_mem_req", 32'(mreq_cyc), 32'd0);
      end
    end

    // Reset while waiting for the fill ack
    resp_en = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    @(posedge clk); #1 cpu_req = 1'b0;
    cyc = 0;
    while (!mem_req && cyc < 10) begin @(posedge clk); #1 cyc++; end
    check1("abort_mem_req", mem_req, 1'b1);
    check1("abort_mem_we", mem_we, 1'b0);
    check("abort_mem_addr", mem_addr, 32'h40);
    check("abort_misses", miss_count, 32'd6);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check1("abort_req_drop", mem_req, 1'b0);
    rst = 1'b0;
    resp_en = 1'b1;
    spur_cnt = spur_cnt + 1;
    base = txq.size();
    repeat (3) @(posedge clk);
    #1;
    check1("late_ack_mem_req", mem_req, 1'b0);
    check1("late_ack_ready", cpu_ready, 1'b0);
    check("post_rst_hits", hit_count, 32'h0);
    check("post_rst_misses", miss_count, 32'h0);
    check("post_rst_rdata", cpu_rdata, 32'h0);
    do_req(1'b0, 32'h40, 32'h0, rd, cyc, mreq_cyc);
    check("refetch_rdata", rd, 32'h12345678);
    check("refetch_misses", miss_count, 32'd1);
    check("refetch_hits", hit_count, 32'd0);
    check_txs(base, 1'b0, 32'h0, 32'h0, 1'b1, 32'h40);

    // Spurious ack in IDLE, then a request held high through cpu_ready
    spur_cnt = spur_cnt + 1;
    base = txq.size();
    repeat (3) @(posedge clk);
    #1;
    check1("spur_mem_req", mem_req, 1'b0);
    check1("spur_ready", cpu_ready, 1'b0);
    check("spur_misses", miss_count, 32'd1);
    check("spur_tx", 32'(txq.size() - base), 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (cpu_ready) pulses++;
    end
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("held_pulses", 32'(pulses), 32'd2);
    check("held_hits", hit_count, 32'd2);
    check("held_misses", miss_count, 32'd1);
    check("held_rdata", cpu_rdata, 32'h12345678);

    // Randomized traffic in a fresh address region after reset
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
    end
    m_hits = 0; m_misses = 0; m_rdata = 0;
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = 32'h0010_0000 + ($urandom_range(0, 3) << 7) + ($urandom_range(0, 7) << 2)
           + $urandom_range(0, 3);
      wd = $urandom;
      resp_lat = $urandom_range(0, 3);
      wa = {a[31:2], 2'b00};
      mi = a[6:2];
      mt = a[31:7];
      ehit = m_valid[mi] && (m_tag[mi] == mt);
      ewb  = !ehit && m_valid[mi] && m_dirty[mi];
      wba  = {m_tag[mi], mi, 2'b00};
      wbd  = truth_rd(wba);
      if (ehit) m_hits = m_hits + 1;
      else begin
        m_misses   = m_misses + 1;
        m_valid[mi] = 1'b1;
        m_tag[mi]   = mt;
        m_dirty[mi] = 1'b0;
      end
      if (we) begin
        truth[wa]   = wd;
        m_dirty[mi] = 1'b1;
      end else begin
        m_rdata = truth_rd(wa);
      end
      base = txq.size();
      do_req(we, a, wd, rd, cyc, mreq_cyc);
      check("rnd_rdata", rd, m_rdata);
      check("rnd_hits", hit_count, m_hits);
      check("rnd_misses", miss_count, m_misses);
      check_txs(base, ewb, wba, wbd, !ehit, wa);
      if (ehit) check("rnd_hit_latency", 32'(cyc), 32'd2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
